// File: rtl/pcie_ss_axis_tlp_checker.sv
// Sink and checker for a PCIe SS AXI-S TLP stream. It applies LFSR-driven
// backpressure, checks that each TLP's beat count matches its header length,
// checks payload DWs against the pattern {pkt_id, dw_index}, and reports
// done/fail status.
module pcie_ss_axis_tlp_checker #(
  parameter int          DATA_WIDTH = 512,
  parameter bit          SB_HEADERS = 1'b1,
  parameter int          NUM_PKTS   = 64,
  parameter int          READY_DUTY = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic                  rx_tlast,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic [255:0]          rx_tuser_hdr,
  output logic [15:0]           pkt_count,
  output logic                  err_framing,
  output logic                  err_data,
  output logic                  done
);

  localparam int          LANES    = DATA_WIDTH / 32;
  // In-band headers occupy the first 8 DWs of the SOP beat.
  localparam logic [31:0] HDR_DW   = SB_HEADERS ? 32'd0 : 32'd8;
  localparam logic [31:0] HDR_BITS = SB_HEADERS ? 32'd0 : 32'd256;
  localparam logic [4:0]  DUTY     = 5'(READY_DUTY);
  localparam logic [15:0] NUM      = 16'(NUM_PKTS);

  typedef enum logic [1:0] {S_SOP, S_PAYLOAD, S_DONE} state_t;

  state_t       state_q;
  logic [15:0]  lfsr_q, lfsr_d;
  logic         rdy_q;
  logic [15:0]  pkt_count_q, pkt_count_d;
  logic         errf_q, errf_d, errd_q, errd_d, done_q, done_d;
  // Per-TLP context captured at SOP, used on later beats.
  logic         has_q;
  logic [10:0]  len_q, exp_q, beat_q;
  logic [15:0]  pkt_q;

  logic         acc, is_sop, reach_d, frm_bad, dat_bad;
  logic [255:0] hdr;
  logic         sop_has_data;
  logic [10:0]  sop_len, sop_exp;
  logic [31:0]  sop_bits;
  logic         cur_has_data;
  logic [10:0]  cur_len, cur_exp, cur_beat, beat_nxt;
  logic [15:0]  cur_pkt;
  logic [LANES-1:0] lane_bad;
  logic         unused_hdr;

  // Header decode, current-beat context and next-state of the status flags.
  always_comb begin
    acc          = rx_tvalid & rdy_q;
    is_sop       = (state_q == S_SOP);
    hdr          = SB_HEADERS ? rx_tuser_hdr : rx_tdata[255:0];
    sop_has_data = hdr[30];
    sop_len      = (hdr[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr[9:0]};
    sop_bits     = {21'd0, sop_len} * 32'd32 + HDR_BITS;
    sop_exp      = sop_has_data ?
                   11'((sop_bits + 32'(DATA_WIDTH) - 32'd1) / 32'(DATA_WIDTH)) : 11'd1;

    cur_has_data = is_sop ? sop_has_data : has_q;
    cur_len      = is_sop ? sop_len      : len_q;
    cur_exp      = is_sop ? sop_exp      : exp_q;
    cur_beat     = is_sop ? 11'd0        : beat_q;
    cur_pkt      = is_sop ? pkt_count_q  : pkt_q;
    beat_nxt     = (cur_beat == 11'h7FF) ? cur_beat : cur_beat + 11'd1;

    // Wrong tlast position, or missing tlast on the expected last beat, or
    // any traffic once done.
    frm_bad = acc && ((state_q == S_DONE) ||
              (rx_tlast ? (cur_beat + 11'd1 != cur_exp) : (cur_beat + 11'd1 == cur_exp)));
    dat_bad = acc && (state_q != S_DONE) && (|lane_bad);

    errf_d      = errf_q | frm_bad;
    errd_d      = errd_q | dat_bad;
    pkt_count_d = pkt_count_q;
    if (acc && rx_tlast && (state_q != S_DONE) && (pkt_count_q != 16'hFFFF))
      pkt_count_d = pkt_count_q + 16'd1;
    reach_d = (state_q == S_DONE) || (pkt_count_d == NUM);
    done_d  = reach_d && !errf_d && !errd_d;

    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Per-lane payload compare: DW position in the TLP stream minus header DWs.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [31:0] g, k;
    assign g = {21'd0, cur_beat} * 32'(LANES) + 32'(j);
    assign k = g - HDR_DW;
    assign lane_bad[j] = cur_has_data && (g >= HDR_DW) && (k < {21'd0, cur_len}) &&
                         (rx_tdata[32*j +: 32] != {cur_pkt, k[15:0]});
  end

  // Header fields we never look at.
  assign unused_hdr = ^{rx_tuser_hdr, hdr[255:32], hdr[31], hdr[29:10]};

  // FSM, backpressure and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SOP;
      lfsr_q      <= LFSR_SEED;
      rdy_q       <= 1'b0;
      pkt_count_q <= 16'd0;
      errf_q      <= 1'b0;
      errd_q      <= 1'b0;
      done_q      <= 1'b0;
      has_q       <= 1'b0;
      len_q       <= 11'd0;
      exp_q       <= 11'd0;
      beat_q      <= 11'd0;
      pkt_q       <= 16'd0;
    end else begin
      lfsr_q      <= lfsr_d;
      rdy_q       <= reach_d ? 1'b1 : ({1'b0, lfsr_q[3:0]} < DUTY);
      pkt_count_q <= pkt_count_d;
      errf_q      <= errf_d;
      errd_q      <= errd_d;
      done_q      <= done_d;
      if (reach_d) begin
        state_q <= S_DONE;
      end else if (acc) begin
        if (is_sop) begin
          has_q <= sop_has_data;
          len_q <= sop_len;
          exp_q <= sop_exp;
          pkt_q <= pkt_count_q;
        end
        beat_q  <= beat_nxt;
        state_q <= rx_tlast ? S_SOP : S_PAYLOAD;
      end
    end
  end

  assign rx_tready   = rdy_q;
  assign pkt_count   = pkt_count_q;
  assign err_framing = errf_q;
  assign err_data    = errd_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pcie_ss_axis_tlp_checker.sv
// Directed bench for the TLP checker. Three instances cover side-band and
// in-band headers and full/partial backpressure. Expected status after each
// beat is queued when the beat is driven and compared once it is accepted.
module tb_pcie_ss_axis_tlp_checker;

  logic         clk = 1'b0;
  logic         rst_a  [3];
  logic         tvalid [3];
  logic         tlast  [3];
  logic [511:0] tdata  [3];
  logic [255:0] thdr   [3];
  logic         rdy    [3];
  logic [15:0]  cnt_o  [3];
  logic         ef_o   [3];
  logic         ed_o   [3];
  logic         dn_o   [3];

  typedef struct {
    int          d;
    logic [15:0] cnt;
    logic        ef;
    logic        ed;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   npk[3] = '{4, 4, 64};
  int   m_cnt[3];
  bit   m_ef[3], m_ed[3], m_reach[3];
  int   lo_cyc = 0;
  int   tot_cyc = 0;

  always #5 clk = ~clk;

  pcie_ss_axis_tlp_checker #(.DATA_WIDTH(512), .SB_HEADERS(1'b1), .NUM_PKTS(4),
    .READY_DUTY(16), .LFSR_SEED(16'hACE1)) u_d0 (
    .clk(clk), .rst(rst_a[0]), .rx_tvalid(tvalid[0]), .rx_tready(rdy[0]),
    .rx_tlast(tlast[0]), .rx_tdata(tdata[0]), .rx_tuser_hdr(thdr[0]),
    .pkt_count(cnt_o[0]), .err_framing(ef_o[0]), .err_data(ed_o[0]), .done(dn_o[0]));

  pcie_ss_axis_tlp_checker #(.DATA_WIDTH(512), .SB_HEADERS(1'b0), .NUM_PKTS(4),
    .READY_DUTY(16), .LFSR_SEED(16'hACE1)) u_d1 (
    .clk(clk), .rst(rst_a[1]), .rx_tvalid(tvalid[1]), .rx_tready(rdy[1]),
    .rx_tlast(tlast[1]), .rx_tdata(tdata[1]), .rx_tuser_hdr(thdr[1]),
    .pkt_count(cnt_o[1]), .err_framing(ef_o[1]), .err_data(ed_o[1]), .done(dn_o[1]));

  pcie_ss_axis_tlp_checker #(.DATA_WIDTH(512), .SB_HEADERS(1'b1), .NUM_PKTS(64),
    .READY_DUTY(8), .LFSR_SEED(16'hACE1)) u_d2 (
    .clk(clk), .rst(rst_a[2]), .rx_tvalid(tvalid[2]), .rx_tready(rdy[2]),
    .rx_tlast(tlast[2]), .rx_tdata(tdata[2]), .rx_tuser_hdr(thdr[2]),
    .pkt_count(cnt_o[2]), .err_framing(ef_o[2]), .err_data(ed_o[2]), .done(dn_o[2]));

  // Backpressure density on the DUTY=8 instance while it is being driven.
  always @(negedge clk) begin
    if (tvalid[2] === 1'b1) begin
      tot_cyc <= tot_cyc + 1;
      if (rdy[2] !== 1'b1) lo_cyc <= lo_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] mk_hdr(input logic [7:0] fmt, input int len);
    logic [255:0] h;
    logic [31:0]  l;
    h = '0;
    l = len;
    h[31:24]  = fmt;
    h[9:0]    = l[9:0];
    h[127:96] = $urandom;
    return h;
  endfunction

  // Expected beat contents: in-band header in DWs 0..7 of beat 0 when
  // inband, pattern DWs below len, random filler elsewhere.
  function automatic logic [511:0] mk_data(input int p, input int beat, input int len,
                                           input bit inband, input logic [255:0] h,
                                           input int bad_k);
    logic [511:0] r;
    logic [31:0]  pv, kv;
    int g, k;
    pv = p;
    for (int l = 0; l < 16; l++) begin
      g  = beat * 16 + l;
      k  = inband ? g - 8 : g;
      kv = k;
      if (inband && g < 8)      r[32*l +: 32] = h[32*l +: 32];
      else if (k < len)         r[32*l +: 32] = (k == bad_k) ? 32'hDEAD_BEEF : {pv[15:0], kv[15:0]};
      else                      r[32*l +: 32] = $urandom;
    end
    return r;
  endfunction

  task automatic rst_dut(input int d);
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
    rst_a[d]  = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("d%0d_rst_tready", d), rdy[d], 0);
    chk($sformatf("d%0d_rst_cnt", d), cnt_o[d], 0);
    chk($sformatf("d%0d_rst_flags", d), {ef_o[d], ed_o[d], dn_o[d]}, 0);
    rst_a[d] = 1'b0;
    m_cnt[d] = 0; m_ef[d] = 0; m_ed[d] = 0; m_reach[d] = 0;
  endtask

  task automatic send_beat(input int d, input logic [255:0] h, input logic [511:0] dat,
                           input logic last, input bit ef, input bit ed);
    exp_t e;
    bit   got;
    if (m_reach[d]) m_ef[d] = 1;
    else begin
      m_ef[d] = m_ef[d] | ef;
      m_ed[d] = m_ed[d] | ed;
      if (last && m_cnt[d] < 65535) m_cnt[d]++;
      if (m_cnt[d] == npk[d]) m_reach[d] = 1;
    end
    e.d = d; e.cnt = 16'(m_cnt[d]); e.ef = m_ef[d]; e.ed = m_ed[d];
    e.dn = m_reach[d] && !m_ef[d] && !m_ed[d];
    sb_q.push_back(e);
    tvalid[d] = 1'b1; tlast[d] = last; tdata[d] = dat; thdr[d] = h;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) got = 1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $error("FAIL d%0d_accept_timeout observed=stalled expected=accepted", d);
      e = sb_q.pop_front();
      return;
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk($sformatf("d%0d_cnt", e.d), cnt_o[e.d], e.cnt);
    chk($sformatf("d%0d_err_framing", e.d), ef_o[e.d], e.ef);
    chk($sformatf("d%0d_err_data", e.d), ed_o[e.d], e.ed);
    chk($sformatf("d%0d_done", e.d), dn_o[e.d], e.dn);
  endtask

  initial begin
    logic [255:0] h;
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b1; tvalid[d] = 1'b0; tlast[d] = 1'b0; tdata[d] = '0; thdr[d] = '0;
    end
    repeat (2) @(posedge clk);
    for (int d = 0; d < 3; d++) rst_dut(d);

    // d0: four single-beat MWr len=16 reach done.
    for (int p = 0; p < 4; p++) begin
      h = mk_hdr(8'h60, 16);
      send_beat(0, h, mk_data(p, 0, 16, 0, h, -1), 1'b1, 0, 0);
    end
    tvalid[0] = 1'b0;
    @(negedge clk);
    chk("d0_tready_in_done", rdy[0], 1);
    // A beat after done is a framing error and drops done.
    h = mk_hdr(8'h60, 16);
    send_beat(0, h, mk_data(4, 0, 16, 0, h, -1), 1'b1, 0, 0);

    // d0: len=32 with DW5 corrupted in beat 0.
    rst_dut(0);
    h = mk_hdr(8'h60, 32);
    send_beat(0, h, mk_data(0, 0, 32, 0, h, 5), 1'b0, 0, 1);
    send_beat(0, '0, mk_data(0, 1, 32, 0, h, -1), 1'b1, 0, 0);

    // d0: reset in the middle of a 4-beat TLP, then a clean TLP with p=0.
    rst_dut(0);
    h = mk_hdr(8'h60, 64);
    send_beat(0, h, mk_data(0, 0, 64, 0, h, -1), 1'b0, 0, 0);
    send_beat(0, '0, mk_data(0, 1, 64, 0, h, -1), 1'b0, 0, 0);
    rst_dut(0);
    h = mk_hdr(8'h60, 16);
    send_beat(0, h, mk_data(0, 0, 16, 0, h, -1), 1'b1, 0, 0);
    tvalid[0] = 1'b0;

    // d1 (in-band header): len=17 in two beats, then MRd with garbage tail.
    h = mk_hdr(8'h60, 17);
    send_beat(1, h, mk_data(0, 0, 17, 1, h, -1), 1'b0, 0, 0);
    send_beat(1, '0, mk_data(0, 1, 17, 1, h, -1), 1'b1, 0, 0);
    h = mk_hdr(8'h00, 1);
    send_beat(1, '0, mk_data(1, 0, 0, 1, h, -1), 1'b1, 0, 0);
    // Same len=17 TLP cut short: tlast on beat 0.
    h = mk_hdr(8'h60, 17);
    send_beat(1, '0, mk_data(2, 0, 17, 1, h, -1), 1'b1, 1, 0);
    // Count reaches NUM_PKTS but done must stay low after the error.
    h = mk_hdr(8'h60, 17);
    send_beat(1, '0, mk_data(3, 0, 17, 1, h, -1), 1'b0, 0, 0);
    send_beat(1, '0, mk_data(3, 1, 17, 1, h, -1), 1'b1, 0, 0);
    tvalid[1] = 1'b0;

    // d2: 64 TLPs of len=8 with tvalid held high under 50% backpressure.
    for (int p = 0; p < 64; p++) begin
      h = mk_hdr(8'h60, 8);
      send_beat(2, h, mk_data(p, 0, 8, 0, h, -1), 1'b1, 0, 0);
    end
    tvalid[2] = 1'b0;
    @(negedge clk);
    chk("d2_tready_duty_near_half",
        ((lo_cyc * 4 >= tot_cyc) && (lo_cyc * 4 <= tot_cyc * 3)) ? 1 : 0, 1);
    chk("d2_final_cnt", cnt_o[2], 64);
    chk("d2_final_done", dn_o[2], 1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
